// File: rtl/dma_sched_pkg.sv
// Shared types and defaults for the DMA transfer scheduler.
package dma_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_DONE,
    HOLDOFF
  } state_t;

  localparam logic DIR_INGRESS = 1'b0;
  localparam logic DIR_EGRESS  = 1'b1;

  localparam int DEF_NUM_QUEUES     = 4;
  localparam int DEF_LEN_WIDTH      = 16;
  localparam int DEF_TIMEOUT_CYCLES = 65535;

endpackage

// File: rtl/dma_xfer_scheduler.sv
// Serializes ingress and egress DMA transfers with alternating priority,
// per-queue egress gating, interrupt masking and a completion timeout.
module dma_xfer_scheduler
  import dma_sched_pkg::*;
#(
  parameter int NUM_QUEUES     = DEF_NUM_QUEUES,
  parameter int LEN_WIDTH      = DEF_LEN_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int QW = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1,
  localparam int TW = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pkt_avail,
  input  logic                 egr_req_valid,
  input  logic [QW-1:0]        egr_req_queue,
  input  logic [LEN_WIDTH-1:0] egr_req_len,
  output logic                 egr_req_ready,
  input  logic [NUM_QUEUES-1:0] q_can_wr,
  output logic                 dma_start,
  output logic                 dma_dir,
  output logic [QW-1:0]        dma_queue,
  output logic [LEN_WIDTH-1:0] dma_len,
  input  logic                 dma_done,
  output logic                 pkt_avail_mask,
  output logic                 busy,
  output logic                 timeout_err,
  output logic                 len_err
);

  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic          last_dir;
  logic [TW-1:0] timeout_cnt;

  logic ingress_ok;
  logic egress_ok;
  logic zero_len_drop;
  logic grant_ingress;
  logic grant_egress;

  // A zero-length request is swallowed in IDLE and blocks any grant that cycle.
  always_comb begin
    ingress_ok    = pkt_avail;
    egress_ok     = egr_req_valid && (egr_req_len != '0) && q_can_wr[egr_req_queue];
    zero_len_drop = (state == IDLE) && egr_req_valid && (egr_req_len == '0);
    grant_ingress = 1'b0;
    grant_egress  = 1'b0;
    if ((state == IDLE) && !zero_len_drop) begin
      if (ingress_ok && egress_ok) begin
        grant_ingress = (last_dir == DIR_EGRESS);
        grant_egress  = (last_dir == DIR_INGRESS);
      end else begin
        grant_ingress = ingress_ok;
        grant_egress  = egress_ok;
      end
    end
    egr_req_ready = zero_len_drop || grant_egress;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      last_dir       <= DIR_EGRESS;
      timeout_cnt    <= '0;
      dma_start      <= 1'b0;
      dma_dir        <= DIR_INGRESS;
      dma_queue      <= '0;
      dma_len        <= '0;
      pkt_avail_mask <= 1'b0;
      busy           <= 1'b0;
      timeout_err    <= 1'b0;
      len_err        <= 1'b0;
    end else begin
      dma_start   <= 1'b0;
      timeout_err <= 1'b0;
      len_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (zero_len_drop) begin
            len_err <= 1'b1;
          end else if (grant_ingress || grant_egress) begin
            state          <= START;
            dma_start      <= 1'b1;
            busy           <= 1'b1;
            pkt_avail_mask <= 1'b1;
            timeout_cnt    <= '0;
            dma_dir        <= grant_egress ? DIR_EGRESS : DIR_INGRESS;
            last_dir       <= grant_egress ? DIR_EGRESS : DIR_INGRESS;
            dma_queue      <= grant_egress ? egr_req_queue : '0;
            dma_len        <= grant_egress ? egr_req_len : '0;
          end
        end
        START: begin
          state <= WAIT_DONE;
        end
        // Completion beats a timeout that expires in the same cycle.
        WAIT_DONE: begin
          if (timeout_cnt != '1) begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
          if (dma_done) begin
            state <= HOLDOFF;
          end else if (timeout_cnt == TO_LIMIT) begin
            timeout_err <= 1'b1;
            state       <= HOLDOFF;
          end
        end
        HOLDOFF: begin
          state          <= IDLE;
          busy           <= 1'b0;
          pkt_avail_mask <= 1'b0;
        end
        default: begin
          state          <= IDLE;
          busy           <= 1'b0;
          pkt_avail_mask <= 1'b0;
        end
      endcase
    end
  end

endmodule
